// File: rtl/spi_pkg.sv
// Shared frame definitions for the SPI RAM: command codes carried in din[9:8]
// and the frame width.
package spi_pkg;

    localparam int unsigned FRAME_W = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    function automatic cmd_e frame_cmd(input logic [FRAME_W-1:0] frame);
        return cmd_e'(frame[FRAME_W-1:FRAME_W-2]);
    endfunction

endpackage

// File: rtl/spi_ram_array.sv
// Byte storage for spi_ram: one write port, one registered read port, no reset.
module spi_ram_array #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    // rdata only moves on a read strobe, so it holds between reads
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/spi_ram.sv
// SPI slave RAM: decodes 10-bit frames into address/data commands over
// spi_ram_array. Define SPI_RAM_AUTOINC_EN to post-increment addresses on data frames.
module spi_ram
    import spi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] din,
    input  logic               rx_valid,
    output logic [7:0]         dout,
    output logic               tx_valid
);

    cmd_e                 cmd;
    logic                 accept;
    logic                 wr_en;
    logic                 rd_en;
    logic                 rd_seen;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [7:0]           rd_byte;

    // The array has no reset, so frames arriving under reset are gated here.
    assign cmd    = frame_cmd(din);
    assign accept = rx_valid & rst_n;
    assign wr_en  = accept && (cmd == CMD_WR_DATA);
    assign rd_en  = accept && (cmd == CMD_RD_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
                CMD_RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
`ifdef SPI_RAM_AUTOINC_EN
                CMD_WR_DATA: wr_addr <= wr_addr + 1'b1;
                CMD_RD_DATA: rd_addr <= rd_addr + 1'b1;
`else
                CMD_WR_DATA, CMD_RD_DATA: ;
`endif
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            rd_seen  <= 1'b0;
        end else if (rx_valid) begin
            tx_valid <= (cmd == CMD_RD_DATA);
            if (cmd == CMD_RD_DATA)
                rd_seen <= 1'b1;
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (din[7:0]),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_byte)
    );

    // The array's read register cannot be reset; masking it with a resettable
    // flag gives dout an asynchronous clear to zero without adding latency.
    assign dout = rd_seen ? rd_byte : '0;

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 256, SHALL set the number of 8-bit storage words.
REQ-002 Parameter ADDR_SIZE, default 8, SHALL set the address width; legal range 1..8, MEM_DEPTH = 2**ADDR_SIZE.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port din  input  10  SHALL carry the frame from the SPI slave: din[9:8] command, din[7:0] address or data.
REQ-006 Port rx_valid  input  1  SHALL qualify din for one cycle per frame.
REQ-007 Port dout  output  8  SHALL carry read data to the SPI slave.
REQ-008 Port tx_valid  output  1  SHALL qualify dout.

Function
REQ-009 din is sampled only on a rising clk edge with rx_valid=1; din is ignored when rx_valid=0.
REQ-010 Command 2'b00 (WR_ADDR) SHALL load wr_addr <= din[ADDR_SIZE-1:0]; higher din bits ignored.
REQ-011 Command 2'b01 (WR_DATA) SHALL write mem[wr_addr] <= din[7:0] at that edge.
REQ-012 Command 2'b10 (RD_ADDR) SHALL load rd_addr <= din[ADDR_SIZE-1:0].
REQ-013 Command 2'b11 (RD_DATA) SHALL load dout <= mem[rd_addr] and set tx_valid=1; latency one clock from the sampling edge.
REQ-014 tx_valid SHALL stay 1 and dout SHALL hold until the next accepted frame whose command is not RD_DATA; that edge clears tx_valid, dout holds its last value.
REQ-015 Back-to-back RD_DATA frames SHALL refresh dout each frame with tx_valid kept high.
REQ-016 Write and read address registers SHALL be independent; a write never moves rd_addr and vice versa.
REQ-017 A RD_DATA frame following a WR_DATA frame to the same address, on any later cycle, SHALL return the newly written byte.
REQ-018 Memory contents are not reset; a read of an unwritten location returns an undefined value, which the bench does not check.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately clear wr_addr, rd_addr, dout to 0 and tx_valid to 0, including mid-transaction.
REQ-020 A frame presented with rx_valid=1 while rst_n=0 SHALL be discarded; memory SHALL NOT be written.
REQ-021 After release, the first accepted frame SHALL be decoded normally with no warm-up cycle.

Configuration
REQ-022 Macro SPI_RAM_AUTOINC_EN defined: after each WR_DATA, wr_addr SHALL increment by 1; after each RD_DATA, rd_addr SHALL increment by 1; both wrap from MEM_DEPTH-1 to 0.
REQ-023 Macro SPI_RAM_AUTOINC_EN undefined: addresses change only on WR_ADDR/RD_ADDR frames, and no increment logic is synthesised.

Structure
REQ-024 Shared package spi_pkg SHALL hold the command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11 and the frame width constant FRAME_W=10.
REQ-025 Storage SHALL be a sub-module spi_ram_array (single write port, single synchronous read port, no reset); spi_ram holds the decode, the address registers and the output handshake.

Verification
REQ-026 Reset test: drive rst_n=0 for 3 cycles with rx_valid=1, din=10'h1FF -> dout=8'h00, tx_valid=0; a later read of the written location shows no write occurred.
REQ-027 Write/read test: frames 10'h012, 10'h1A5, 10'h212, 10'h3xx -> dout=8'hA5, tx_valid=1 one cycle after the RD_DATA edge.
REQ-028 Hold test: after REQ-027, idle for 20 cycles -> dout=8'hA5, tx_valid=1 throughout; then frame 10'h000 -> tx_valid=0 the next cycle, dout still 8'hA5.
REQ-029 Address isolation test: WR_ADDR 0x10, RD_ADDR 0x20, WR_DATA 0x5A, RD_DATA -> dout = mem[0x20] (previously written 0x33), not 0x5A.
REQ-030 Auto-increment test (SPI_RAM_AUTOINC_EN defined): WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, RD_ADDR 0xFF, RD_DATA x2 -> dout 0x11 then 0x22 (address 0 after wrap); the same sequence without the macro -> dout 0x22 then 0x22.
REQ-031 Reset mid-read test: assert rst_n=0 while tx_valid=1 -> tx_valid=0 and dout=0 asynchronously, before the next clk edge.
